// File: rtl/rs_sbox_key_gen_if.sv
// Key-load / S-vector handshake bundle for rs_sbox_key_gen.
// master = key producer and S-vector consumer, slave = the generator.
interface rs_sbox_key_gen_if #(
   parameter int MAX_KEY_BITS = 256
);
   logic [MAX_KEY_BITS-1:0]   key_in;
   logic [1:0]                key_len;
   logic                      in_valid;
   logic                      in_ready;
   logic [MAX_KEY_BITS/2-1:0] s_out;
   logic                      out_valid;
   logic                      out_ready;
   logic                      out_err;

   modport master (
      output key_in, key_len, in_valid, out_ready,
      input  in_ready, s_out, out_valid, out_err
   );

   modport slave (
      input  key_in, key_len, in_valid, out_ready,
      output in_ready, s_out, out_valid, out_err
   );
endinterface

// File: rtl/rs_sbox_key_gen.sv
// Iterative Twofish RS S-vector generator (IDLE/RUN/HOLD, valid/ready both sides).
// Define RS_PARALLEL_CHUNK_EN to process a full 8-byte chunk per cycle instead of one byte.
module rs_sbox_key_gen #(
   parameter int          MAX_KEY_BITS = 256,
   parameter logic [8:0]  GF_POLY      = 9'h14D
) (
   input  logic                clk,
   input  logic                rst_n,
   rs_sbox_key_gen_if.slave    bus
);
   localparam int KB    = MAX_KEY_BITS;
   localparam int SW    = MAX_KEY_BITS / 2;
   localparam int MAX_K = MAX_KEY_BITS / 64;
`ifdef RS_PARALLEL_CHUNK_EN
   localparam int CNT_W = 2;
   localparam int SHIFT = 64;
`else
   localparam int CNT_W = 5;
   localparam int SHIFT = 8;
`endif

   typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

   state_t             r_state;
   logic [KB-1:0]      r_keyShift;
   logic [1:0]         r_kLast;
   logic [CNT_W-1:0]   r_cnt;
   logic [SW-1:0]      r_sVec;
   logic               r_err;
   logic               r_inReady;
   logic               r_outValid;
`ifndef RS_PARALLEL_CHUNK_EN
   logic [31:0]        r_acc;
`endif

   logic [1:0]         w_kLast;
   logic               w_lenErr;
   logic [31:0]        w_word;
   logic [1:0]         w_wordIdx;
   logic               w_colLast;
   logic               w_lastStep;

   function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = '0;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = x[7] ? ({x[6:0], 1'b0} ^ GF_POLY[7:0]) : {x[6:0], 1'b0};
      end
      return p;
   endfunction

   function automatic logic [7:0] rsCoef(input logic [1:0] r, input logic [2:0] c);
      logic [63:0] row;
      case (r)
         2'd0:    row = 64'h01A4_5587_5A58_DB9E;
         2'd1:    row = 64'hA456_82F3_1EC6_68E5;
         2'd2:    row = 64'h02A1_FCC1_47AE_3D19;
         default: row = 64'hA455_875A_58DB_9E03;
      endcase
      row = row << {c, 3'b000};
      return row[63:56];
   endfunction

   // Oversized or reserved lengths fall back to the widest key we support.
   always_comb begin
      w_lenErr = 1'b0;
      w_kLast  = 2'(MAX_K - 1);
      if (bus.key_len == 2'd3 || (int'(bus.key_len) + 2) > MAX_K)
         w_lenErr = 1'b1;
      else
         w_kLast = bus.key_len + 2'd1;
   end

`ifdef RS_PARALLEL_CHUNK_EN
   always_comb begin
      w_word = '0;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 8; c++)
            w_word[8*r +: 8] = w_word[8*r +: 8] ^
                               gfMul(rsCoef(2'(r), 3'(c)), r_keyShift[KB-1-8*c -: 8]);
      w_wordIdx  = r_kLast - r_cnt;
      w_colLast  = 1'b1;
      w_lastStep = (r_cnt == r_kLast);
   end
`else
   always_comb begin
      w_word = '0;
      for (int r = 0; r < 4; r++)
         w_word[8*r +: 8] = r_acc[8*r +: 8] ^
                            gfMul(rsCoef(2'(r), r_cnt[2:0]), r_keyShift[KB-1 -: 8]);
      w_wordIdx  = r_kLast - r_cnt[4:3];
      w_colLast  = (r_cnt[2:0] == 3'd7);
      w_lastStep = (r_cnt == {r_kLast, 3'b111});
   end
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_keyShift <= '0;
         r_kLast    <= '0;
         r_cnt      <= '0;
         r_sVec     <= '0;
         r_err      <= 1'b0;
         r_inReady  <= 1'b1;
         r_outValid <= 1'b0;
`ifndef RS_PARALLEL_CHUNK_EN
         r_acc      <= '0;
`endif
      end else begin
         case (r_state)
            IDLE: begin
               if (bus.in_valid && r_inReady) begin
                  r_keyShift <= bus.key_in;
                  r_kLast    <= w_kLast;
                  r_err      <= w_lenErr;
                  r_cnt      <= '0;
                  r_sVec     <= '0;
                  r_inReady  <= 1'b0;
                  r_state    <= RUN;
`ifndef RS_PARALLEL_CHUNK_EN
                  r_acc      <= '0;
`endif
               end
            end
            RUN: begin
               r_keyShift <= r_keyShift << SHIFT;
               r_cnt      <= r_cnt + 1'b1;
`ifndef RS_PARALLEL_CHUNK_EN
               r_acc      <= w_colLast ? 32'h0 : w_word;
`endif
               // Chunk j lands in word k-1-j, so the first key bytes end up highest.
               if (w_colLast) begin
                  for (int w = 0; w < MAX_K; w++)
                     if (w_wordIdx == 2'(w)) r_sVec[32*w +: 32] <= w_word;
               end
               if (w_lastStep) begin
                  r_state    <= HOLD;
                  r_outValid <= 1'b1;
               end
            end
            HOLD: begin
               if (bus.out_ready) begin
                  r_state    <= IDLE;
                  r_outValid <= 1'b0;
                  r_inReady  <= 1'b1;
               end
            end
            default: begin
               r_state    <= IDLE;
               r_outValid <= 1'b0;
               r_inReady  <= 1'b1;
            end
         endcase
      end
   end

   assign bus.in_ready  = r_inReady;
   assign bus.out_valid = r_outValid;
   assign bus.s_out     = r_sVec;
   assign bus.out_err   = r_err & r_outValid;

endmodule

// File: tb/tb_rs_sbox_key_gen.sv
// Self-checking bench for rs_sbox_key_gen: vector table, random keys against a
// GF(2^8) reference model, plus backpressure, back-to-back and mid-run reset sequences.
module tb_rs_sbox_key_gen;
   localparam int MKB = 256;

   logic clk = 1'b0;
   logic rstN;
   int   checks   = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   rs_sbox_key_gen_if #(.MAX_KEY_BITS(MKB)) bus ();

   rs_sbox_key_gen #(.MAX_KEY_BITS(MKB), .GF_POLY(9'h14D)) dut (
      .clk   (clk),
      .rst_n (rstN),
      .bus   (bus)
   );

   localparam logic [63:0] RS_ROWS [4] = '{
      64'h01A45587_5A58DB9E,
      64'hA45682F3_1EC668E5,
      64'h02A1FCC1_47AE3D19,
      64'hA455875A_58DB9E03
   };

   typedef struct {
      logic [255:0] key;
      logic [1:0]   len;
      logic [127:0] expS;
      logic         expErr;
   } vec_t;

   // Carry-less 16-bit product, then long-division by the field polynomial.
   function automatic logic [7:0] refMul(input logic [7:0] a, input logic [7:0] b);
      logic [15:0] prod;
      prod = '0;
      for (int i = 0; i < 8; i++)
         if (b[i]) prod = prod ^ ({8'h00, a} << i);
      for (int t = 14; t >= 8; t--)
         if (prod[t]) prod = prod ^ (16'h014D << (t - 8));
      return prod[7:0];
   endfunction

   function automatic int refK(input logic [1:0] len);
      return (len == 2'd3) ? 4 : int'(len) + 2;
   endfunction

   function automatic int refLat(input int k);
`ifdef RS_PARALLEL_CHUNK_EN
      return k;
`else
      return 8 * k;
`endif
   endfunction

   function automatic logic [127:0] refSvec(input logic [255:0] key, input logic [1:0] len);
      logic [127:0] s;
      logic [7:0]   y;
      int           k;
      s = '0;
      k = refK(len);
      for (int j = 0; j < k; j++)
         for (int r = 0; r < 4; r++) begin
            y = '0;
            for (int c = 0; c < 8; c++)
               y = y ^ refMul(RS_ROWS[r][63-8*c -: 8], key[255-8*(8*j+c) -: 8]);
            s[32*(k-1-j) + 8*r +: 8] = y;
         end
      return s;
   endfunction

   task automatic checkOutput(input string name, input logic [255:0] actual,
                              input logic [255:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
      end
   endtask

   task automatic waitValid(output int lat);
      lat = 0;
      while (!bus.out_valid && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic applyStimulus(input logic [255:0] key, input logic [1:0] len,
                                output int lat);
      int guard;
      guard = 0;
      @(negedge clk);
      while (!bus.in_ready && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      checkOutput("inReadyBeforeAccept", 256'(bus.in_ready), 256'd1);
      bus.key_in   = key;
      bus.key_len  = len;
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      waitValid(lat);
   endtask

   task automatic releaseOutput();
      @(negedge clk);
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      checkOutput("inReadyAfterHold", 256'(bus.in_ready), 256'd1);
      checkOutput("outValidAfterHold", 256'(bus.out_valid), 256'd0);
   endtask

   task automatic runAndCheck(input logic [255:0] key, input logic [1:0] len,
                              input logic [127:0] expS, input logic expErr);
      int lat;
      applyStimulus(key, len, lat);
      checkOutput("latency", 256'(lat), 256'(refLat(refK(len))));
      checkOutput("sOut", 256'(bus.s_out), 256'(expS));
      checkOutput("outErr", 256'(bus.out_err), 256'(expErr));
      releaseOutput();
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      vec_t         vecs [9];
      logic [255:0] rKey;
      logic [255:0] key2;
      logic [1:0]   rLen;
      int           lat;

      vecs[0] = '{256'h0, 2'd0, 128'h0, 1'b0};
      vecs[1] = '{{8'h01, 248'h0}, 2'd0, {64'h0, 32'hA402A401, 32'h0}, 1'b0};
      vecs[2] = '{{8'h02, 248'h0}, 2'd0, {64'h0, 32'h05040502, 32'h0}, 1'b0};
      vecs[3] = '{{120'h0, 8'h01, 128'h0}, 2'd0, {96'h0, 32'h0319E59E}, 1'b0};
      vecs[4] = '{{8'h01, 240'h0, 8'h01}, 2'd2, {32'hA402A401, 64'h0, 32'h0319E59E}, 1'b0};
      vecs[5] = '{{8'h01, 240'h0, 8'h01}, 2'd3, {32'hA402A401, 64'h0, 32'h0319E59E}, 1'b1};
      vecs[6] = '{{8'h01, 248'h0}, 2'd1, {32'h0, 32'hA402A401, 64'h0}, 1'b0};
      vecs[7] = '{{184'h0, 8'h01, 64'h0}, 2'd1, {96'h0, 32'h0319E59E}, 1'b0};
      vecs[8] = '{{8'h01, 240'h0, 8'h01}, 2'd0, {64'h0, 32'hA402A401, 32'h0}, 1'b0};

      bus.key_in    = '0;
      bus.key_len   = '0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      rstN          = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("resetInReady", 256'(bus.in_ready), 256'd1);
      checkOutput("resetOutValid", 256'(bus.out_valid), 256'd0);
      checkOutput("resetOutErr", 256'(bus.out_err), 256'd0);
      checkOutput("resetSOut", 256'(bus.s_out), 256'd0);
      @(negedge clk);
      rstN = 1'b1;

      bus.out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("idleOutReadyIgnored", 256'(bus.out_valid), 256'd0);
      checkOutput("idleInReady", 256'(bus.in_ready), 256'd1);
      bus.out_ready = 1'b0;

      for (int i = 0; i < 9; i++)
         runAndCheck(vecs[i].key, vecs[i].len, vecs[i].expS, vecs[i].expErr);

      for (int n = 0; n < 24; n++) begin
         for (int w = 0; w < 8; w++) rKey[32*w +: 32] = $urandom;
         rLen = 2'($urandom_range(0, 3));
         runAndCheck(rKey, rLen, refSvec(rKey, rLen), rLen == 2'd3);
      end

      // Backpressure: output must hold while the consumer stalls.
      for (int w = 0; w < 8; w++) rKey[32*w +: 32] = $urandom;
      for (int w = 0; w < 8; w++) key2[32*w +: 32] = $urandom;
      applyStimulus(rKey, 2'd0, lat);
      checkOutput("bpLatency", 256'(lat), 256'(refLat(2)));
      for (int c = 0; c < 10; c++) begin
         @(posedge clk); #1;
         checkOutput("bpSOutStable", 256'(bus.s_out), 256'(refSvec(rKey, 2'd0)));
         checkOutput("bpInReadyLow", 256'(bus.in_ready), 256'd0);
         checkOutput("bpOutValidHeld", 256'(bus.out_valid), 256'd1);
      end

      @(negedge clk);
      bus.out_ready = 1'b1;
      bus.key_in    = key2;
      bus.key_len   = 2'd1;
      bus.in_valid  = 1'b1;
      @(posedge clk); #1;
      checkOutput("b2bInReadyRise", 256'(bus.in_ready), 256'd1);
      checkOutput("b2bOutValidDrop", 256'(bus.out_valid), 256'd0);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      checkOutput("b2bAccepted", 256'(bus.in_ready), 256'd0);
      waitValid(lat);
      checkOutput("b2bLatency", 256'(lat), 256'(refLat(3)));
      checkOutput("b2bSOut", 256'(bus.s_out), 256'(refSvec(key2, 2'd1)));
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      checkOutput("b2bDone", 256'(bus.in_ready), 256'd1);

      // Reset in the middle of RUN discards the partial result.
      @(negedge clk);
      bus.key_in   = rKey;
      bus.key_len  = 2'd2;
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      checkOutput("runInReadyLow", 256'(bus.in_ready), 256'd0);
      repeat (5) @(posedge clk);
      @(negedge clk);
      rstN = 1'b0;
      @(posedge clk); #1;
      checkOutput("abortOutValid", 256'(bus.out_valid), 256'd0);
      checkOutput("abortInReady", 256'(bus.in_ready), 256'd1);
      checkOutput("abortSOut", 256'(bus.s_out), 256'd0);
      @(negedge clk);
      rstN = 1'b1;
      runAndCheck(key2, 2'd2, refSvec(key2, 2'd2), 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
